// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer, the pulse generator and the
// display decoder: phase encoding, field widths and default phase lengths.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRELIM = 3'd1,
    GAME   = 3'd2,
    ANSWER = 3'd3,
    POST   = 3'd4,
    DONE   = 3'd5
  } phase_t;

  localparam int LEVEL_W = 5;
  localparam int SEC_W   = 5;

  localparam int DEF_PRELIM_SEC = 3;
  localparam int DEF_GAME_SEC   = 10;
  localparam int DEF_ANSWER_SEC = 10;
  localparam int DEF_POST_SEC   = 3;
  // Cumulative level*5M period decrement stays positive only up to level 5.
  localparam int DEF_MAX_LEVEL  = 5;

  // True when v fits a 5-bit seconds/level field and is non-zero.
  function automatic bit inFieldRange(input int v);
    return (v >= 1) && (v <= 31);
  endfunction

endpackage

// File: rtl/sec_down_timer.sv
// Whole-second down counter for the phase timer.
//   Clk100M  system clock
//   reset    synchronous, active-high; clears the count
//   load     load loadVal this cycle (wins over the tick)
//   loadVal  phase length to load
//   tick     1 Hz strobe
//   secLeft  seconds remaining
//   expire   tick while secLeft==1 (combinational); the owner reloads on it
module sec_down_timer
  import game_pkg::*;
(
  input  logic             Clk100M,
  input  logic             reset,
  input  logic             load,
  input  logic [SEC_W-1:0] loadVal,
  input  logic             tick,
  output logic [SEC_W-1:0] secLeft,
  output logic             expire
);

  assign expire = tick && (secLeft == SEC_W'(1));

  // The count stops at 1: the final tick is consumed by the owner's reload,
  // so a timed phase never shows 0. A zero count (IDLE/DONE) ignores ticks.
  always_ff @(posedge Clk100M) begin
    if (reset) begin
      secLeft <= '0;
    end else if (load) begin
      secLeft <= loadVal;
    end else if (tick && (secLeft > SEC_W'(1))) begin
      secLeft <= secLeft - SEC_W'(1);
    end
  end

endmodule

// File: rtl/game_phase_ctrl.sv
// Game sequencer: IDLE -> PRELIM -> GAME -> ANSWER -> POST -> (PRELIM | DONE),
// each timed phase measured in Clk1Hz ticks.
//   Clk100M, reset             clock and synchronous active-high reset
//   Clk1Hz                     one-cycle 1 Hz tick
//   start                      begin a game (IDLE only)
//   answerValid/answerCorrect  player answer strobe and its verdict (ANSWER only)
//   prelimPeriod..postPeriod   registered one-hot phase decode
//   level, levelChng           current level and one-cycle pulse after it rises
//   secLeft                    seconds remaining in the timed phase, else 0
//   lastCorrect, win, gameOver result of last answer and sticky end flags
module game_phase_ctrl
  import game_pkg::*;
#(
  parameter int PRELIM_SEC = DEF_PRELIM_SEC,
  parameter int GAME_SEC   = DEF_GAME_SEC,
  parameter int ANSWER_SEC = DEF_ANSWER_SEC,
  parameter int POST_SEC   = DEF_POST_SEC,
  parameter int MAX_LEVEL  = DEF_MAX_LEVEL
) (
  input  logic               Clk100M,
  input  logic               reset,
  input  logic               Clk1Hz,
  input  logic               start,
  input  logic               answerValid,
  input  logic               answerCorrect,
  output logic               prelimPeriod,
  output logic               gamePeriod,
  output logic               answerPeriod,
  output logic               postPeriod,
  output logic [LEVEL_W-1:0] level,
  output logic               levelChng,
  output logic [SEC_W-1:0]   secLeft,
  output logic               lastCorrect,
  output logic               win,
  output logic               gameOver
);

  if (!inFieldRange(PRELIM_SEC) || !inFieldRange(GAME_SEC) ||
      !inFieldRange(ANSWER_SEC) || !inFieldRange(POST_SEC) ||
      !inFieldRange(MAX_LEVEL)) begin : gParamCheck
    $error("game_phase_ctrl: phase lengths and MAX_LEVEL must be in 1..31");
  end

  localparam logic [LEVEL_W-1:0] MAX_LEVEL_V = LEVEL_W'(MAX_LEVEL);

  phase_t           state, nextState;
  logic             load, expire;
  logic [SEC_W-1:0] loadVal;
  logic             levelUp, levelUpPend;
  logic             setWin, setOver;
  logic             capture, captureVal;

  sec_down_timer uTimer (
    .Clk100M (Clk100M),
    .reset   (reset),
    .load    (load),
    .loadVal (loadVal),
    .tick    (Clk1Hz),
    .secLeft (secLeft),
    .expire  (expire)
  );

  always_comb begin
    nextState  = state;
    levelUp    = 1'b0;
    setWin     = 1'b0;
    setOver    = 1'b0;
    capture    = 1'b0;
    captureVal = 1'b0;
    loadVal    = '0;
    unique case (state)
      IDLE:   if (start) nextState = PRELIM;
      PRELIM: if (expire) nextState = GAME;
      GAME:   if (expire) nextState = ANSWER;
      ANSWER: begin
        // A submission arriving with the final tick still counts.
        if (answerValid) begin
          nextState  = POST;
          capture    = 1'b1;
          captureVal = answerCorrect;
        end else if (expire) begin
          nextState  = POST;
          capture    = 1'b1;
          captureVal = 1'b0;
        end
      end
      POST: begin
        if (expire) begin
          if (!lastCorrect) begin
            setOver   = 1'b1;
            nextState = DONE;
          end else if (level < MAX_LEVEL_V) begin
            levelUp   = 1'b1;
            nextState = PRELIM;
          end else begin
            setWin    = 1'b1;
            nextState = DONE;
          end
        end
      end
      DONE:    nextState = DONE;
      default: nextState = IDLE;
    endcase
    // The timer is reloaded with the length of whichever phase is entered;
    // entering DONE loads 0 so secLeft reads 0 there.
    unique case (nextState)
      PRELIM:  loadVal = SEC_W'(PRELIM_SEC);
      GAME:    loadVal = SEC_W'(GAME_SEC);
      ANSWER:  loadVal = SEC_W'(ANSWER_SEC);
      POST:    loadVal = SEC_W'(POST_SEC);
      default: loadVal = '0;
    endcase
  end

  assign load = (nextState != state);

  always_ff @(posedge Clk100M) begin
    if (reset) begin
      state        <= IDLE;
      prelimPeriod <= 1'b0;
      gamePeriod   <= 1'b0;
      answerPeriod <= 1'b0;
      postPeriod   <= 1'b0;
      level        <= LEVEL_W'(1);
      levelUpPend  <= 1'b0;
      levelChng    <= 1'b0;
      lastCorrect  <= 1'b0;
      win          <= 1'b0;
      gameOver     <= 1'b0;
    end else begin
      state        <= nextState;
      prelimPeriod <= (nextState == PRELIM);
      gamePeriod   <= (nextState == GAME);
      answerPeriod <= (nextState == ANSWER);
      postPeriod   <= (nextState == POST);
      // levelChng lags the level update by one cycle so the symbol-rate
      // generator samples an already-stable level.
      levelUpPend  <= levelUp;
      levelChng    <= levelUpPend;
      if ((state == IDLE) && start) begin
        level       <= LEVEL_W'(1);
        lastCorrect <= 1'b0;
      end
      if (levelUp) level <= level + LEVEL_W'(1);
      if (capture) lastCorrect <= captureVal;
      if (setWin)  win <= 1'b1;
      if (setOver) gameOver <= 1'b1;
    end
  end

endmodule
